// File: rtl/fetch_aligner_pkg.sv
// Shared constants and types for the IF-stage fetch aligner.
package fetch_aligner_pkg;

  localparam int unsigned HW_W           = 16;
  localparam int unsigned BUF_HW_DEFAULT = 4;
  localparam logic [31:0] BOOT_PC_DEFAULT = 32'h0000_0000;
  // Opcode quadrant marking a 32-bit instruction; anything else is RVC.
  localparam logic [1:0]  OPQ_32B        = 2'b11;

  typedef logic [HW_W-1:0] hw_t;

  typedef enum logic [1:0] {
    HW_NONE = 2'd0,
    HW_ONE  = 2'd1,
    HW_TWO  = 2'd2
  } hw_cnt_e;

  function automatic logic is_rvc(input hw_t hw);
    return hw[1:0] != OPQ_32B;
  endfunction

endpackage

// File: rtl/fetch_hw_queue.sv
// Halfword shift buffer: head at entry 0, pops 0-2 and appends 0-2 halfwords per cycle.
module fetch_hw_queue
  import fetch_aligner_pkg::*;
#(
  parameter int unsigned DEPTH = BUF_HW_DEFAULT,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  hw_cnt_e       push_n,
  input  hw_t           push_lo,
  input  hw_t           push_hi,
  input  hw_cnt_e       pop_n,
  output hw_t           head0,
  output hw_t           head1,
  output logic [CW-1:0] cnt
);

  hw_t           buf_q [DEPTH];
  hw_t           buf_d [DEPTH];
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [CW-1:0] kept;

  // Shift out popped entries first, then append behind the survivors.
  always_comb begin
    kept  = cnt_q - CW'(pop_n);
    cnt_d = kept + CW'(push_n);
    for (int unsigned i = 0; i < DEPTH; i++) begin
      buf_d[i] = '0;
      if (i + 32'(pop_n) < DEPTH)
        buf_d[i] = buf_q[i + 32'(pop_n)];
      if (i == 32'(kept) && push_n != HW_NONE)
        buf_d[i] = push_lo;
      if (i == 32'(kept) + 32'd1 && push_n == HW_TWO)
        buf_d[i] = push_hi;
    end
    if (flush)
      cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q <= '{default: '0};
      cnt_q <= '0;
    end else begin
      buf_q <= buf_d;
      cnt_q <= cnt_d;
    end
  end

  assign head0 = buf_q[0];
  assign head1 = buf_q[1];
  assign cnt   = cnt_q;

endmodule

// File: rtl/fetch_aligner.sv
// IF-stage fetch aligner: turns 32-bit cache words into one raw instruction + PC per handshake.
module fetch_aligner
  import fetch_aligner_pkg::*;
#(
  parameter logic [31:0] BOOT_PC = BOOT_PC_DEFAULT,
  parameter int unsigned BUF_HW  = BUF_HW_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] fetch_addr,
  input  logic        word_valid,
  input  logic [31:0] word_data,
  output logic        word_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic        inst_is_rvc
);

  logic        run_q;
  logic        skip_q;
  logic [31:0] head_pc_q;
  logic [31:0] fetch_addr_q;

  hw_t         head0;
  hw_t         head1;
  logic [2:0]  cnt;
  logic        head_rvc;
  logic        accept;
  logic        pop;
  hw_cnt_e     push_n;
  hw_cnt_e     pop_n;
  hw_t         push_lo;
  hw_t         push_hi;

  fetch_hw_queue #(
    .DEPTH (BUF_HW)
  ) u_queue (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (redirect_valid),
    .push_n  (push_n),
    .push_lo (push_lo),
    .push_hi (push_hi),
    .pop_n   (pop_n),
    .head0   (head0),
    .head1   (head1),
    .cnt     (cnt)
  );

  assign head_rvc    = is_rvc(head0);
  assign inst_valid  = (cnt >= 3'd1 && head_rvc) || (cnt >= 3'd2);
  assign inst_data   = head_rvc ? {16'h0000, head0} : {head1, head0};
  assign inst_is_rvc = head_rvc;
  assign inst_pc     = head_pc_q;
  assign fetch_addr  = fetch_addr_q;

  // run_q keeps the cache port idle until reset release has been seen on a clock edge.
  assign word_ready  = run_q && (cnt <= 3'd2) && !redirect_valid;
  assign accept      = word_valid && word_ready;
  assign pop         = inst_valid && inst_ready && !redirect_valid;

  always_comb begin
    push_n  = HW_NONE;
    push_lo = '0;
    push_hi = '0;
    pop_n   = HW_NONE;
    if (accept) begin
      if (skip_q) begin
        push_n  = HW_ONE;
        push_lo = word_data[31:16];
      end else begin
        push_n  = HW_TWO;
        push_lo = word_data[15:0];
        push_hi = word_data[31:16];
      end
    end
    if (pop)
      pop_n = head_rvc ? HW_ONE : HW_TWO;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q        <= 1'b0;
      skip_q       <= 1'b0;
      head_pc_q    <= BOOT_PC;
      fetch_addr_q <= {BOOT_PC[31:2], 2'b00};
    end else begin
      run_q <= 1'b1;
      if (redirect_valid) begin
        head_pc_q    <= redirect_pc;
        fetch_addr_q <= {redirect_pc[31:2], 2'b00};
        skip_q       <= redirect_pc[1];
      end else begin
        if (accept) begin
          fetch_addr_q <= fetch_addr_q + 32'd4;
          skip_q       <= 1'b0;
        end
        if (pop)
          head_pc_q <= head_pc_q + (head_rvc ? 32'd2 : 32'd4);
      end
    end
  end

endmodule

// File: tb/tb_fetch_aligner.sv
// Bench for fetch_aligner: plays the I-cache from a word memory and predicts the instruction stream by walking PCs.
module tb_fetch_aligner;

  localparam logic [31:0] BOOT = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] fetch_addr;
  logic        word_valid;
  logic [31:0] word_data;
  logic        word_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_is_rvc;

  fetch_aligner #(
    .BOOT_PC (BOOT),
    .BUF_HW  (4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_addr     (fetch_addr),
    .word_valid     (word_valid),
    .word_data      (word_data),
    .word_ready     (word_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .inst_is_rvc    (inst_is_rvc)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [1024];
  logic [31:0] exp_pc;
  logic [31:0] exp_fa;
  int          vectors = 0;
  int          miscompares = 0;
  int          npops = 0;

  function automatic logic [15:0] hw_at(input logic [31:0] a);
    logic [31:0] w;
    w = mem[a[11:2]];
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive, then check outputs against the PC-walk model and advance it.
  task automatic cycle(input bit wv, input bit rv, input logic [31:0] rpc, input bit ir);
    logic [15:0] lo;
    logic [31:0] exp_d;
    logic [31:0] len;
    @(posedge clk);
    #1;
    word_valid     = wv;
    word_data      = wv ? mem[exp_fa[11:2]] : $urandom;
    redirect_valid = rv;
    redirect_pc    = rpc;
    inst_ready     = ir;
    #1;
    chk("fetch_addr", fetch_addr, exp_fa);
    if (rv) chk("word_ready_on_redirect", 32'(word_ready), 32'd0);
    lo = hw_at(exp_pc);
    if (lo[1:0] != 2'b11) begin
      exp_d = {16'h0000, lo};
      len   = 32'd2;
    end else begin
      exp_d = {hw_at(exp_pc + 32'd2), lo};
      len   = 32'd4;
    end
    if (inst_valid) begin
      chk("inst_pc", inst_pc, exp_pc);
      chk("inst_data", inst_data, exp_d);
      chk("inst_is_rvc", 32'(inst_is_rvc), 32'(len == 32'd2));
    end
    if (rv) begin
      exp_pc = rpc;
      exp_fa = {rpc[31:2], 2'b00};
    end else begin
      if (wv && word_ready) exp_fa = exp_fa + 32'd4;
      if (inst_valid && ir) begin
        exp_pc = exp_pc + len;
        npops++;
      end
    end
  endtask

  task automatic wait_valid(input int unsigned max_cyc, input string tag);
    int unsigned n = 0;
    do begin
      cycle(1'b1, 1'b0, '0, 1'b0);
      n++;
    end while (!inst_valid && n < max_cyc);
    chk({tag, "_valid"}, 32'(inst_valid), 32'd1);
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk);
    #3;
    rst_n          = 1'b0;
    word_valid     = 1'b0;
    redirect_valid = 1'b0;
    inst_ready     = 1'b0;
    #1;
    chk({tag, "_inst_valid"}, 32'(inst_valid), 32'd0);
    chk({tag, "_inst_pc"}, inst_pc, BOOT);
    chk({tag, "_inst_data"}, inst_data, 32'd0);
    chk({tag, "_fetch_addr"}, fetch_addr, {BOOT[31:2], 2'b00});
    chk({tag, "_word_ready"}, 32'(word_ready), 32'd0);
    repeat (2) @(posedge clk);
    #3;
    rst_n  = 1'b1;
    exp_pc = BOOT;
    exp_fa = {BOOT[31:2], 2'b00};
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] w;
    rst_n          = 1'b1;
    word_valid     = 1'b0;
    word_data      = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    inst_ready     = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    mem[0]   = 32'h00A0_0513;
    mem[1]   = 32'h4581_0505;
    mem[64]  = 32'h4581_0001;
    mem[256] = 32'h0513_0505;
    mem[257] = 32'h0000_00A0;
    for (int i = 192; i < 200; i++) begin
      w = $urandom;
      if (w[1:0] == 2'b11)   w[1:0]   = 2'b00;
      if (w[17:16] == 2'b11) w[17:16] = 2'b01;
      mem[i] = w;
    end

    // Reset and sequential stream from BOOT_PC
    do_reset("reset");
    repeat (8) cycle(1'b1, 1'b0, '0, 1'b1);

    // Straddle across words at 0x400
    cycle(1'b0, 1'b1, 32'h0000_0400, 1'b1);
    cycle(1'b1, 1'b0, '0, 1'b1);
    cycle(1'b0, 1'b0, '0, 1'b1);
    chk("straddle_rvc_pc", inst_pc, 32'h0000_0400);
    chk("straddle_rvc_data", inst_data, 32'h0000_0505);
    repeat (3) begin
      cycle(1'b0, 1'b0, '0, 1'b1);
      chk("straddle_wait", 32'(inst_valid), 32'd0);
    end
    cycle(1'b1, 1'b0, '0, 1'b1);
    chk("straddle_accept_cycle", 32'(inst_valid), 32'd0);
    cycle(1'b0, 1'b0, '0, 1'b1);
    chk("straddle_32_pc", inst_pc, 32'h0000_0402);
    chk("straddle_32_data", inst_data, 32'h00A0_0513);

    // Misaligned redirect target skips the low halfword
    cycle(1'b0, 1'b1, 32'h0000_0102, 1'b1);
    wait_valid(10, "misaligned");
    chk("misaligned_pc", inst_pc, 32'h0000_0102);
    chk("misaligned_data", inst_data, 32'h0000_4581);
    chk("misaligned_rvc", 32'(inst_is_rvc), 32'd1);

    // Downstream stall with RVC stream
    cycle(1'b0, 1'b1, 32'h0000_0300, 1'b0);
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 1'b0, '0, 1'b0);
      if (i >= 2) chk("stall_word_ready", 32'(word_ready), 32'd0);
    end
    repeat (30) cycle(1'b1, 1'b0, '0, 1'b1);

    // Redirect colliding with word accept and pop
    wait_valid(10, "collide_pre");
    cycle(1'b1, 1'b1, 32'h0000_0200, 1'b1);
    wait_valid(10, "collide_post");
    chk("collide_pc", inst_pc, 32'h0000_0200);

    // Address wrap modulo 2^32
    cycle(1'b0, 1'b1, 32'hFFFF_FFFA, 1'b1);
    repeat (10) cycle(1'b1, 1'b0, '0, 1'b1);

    // Reset mid-straddle
    cycle(1'b0, 1'b1, 32'h0000_0400, 1'b1);
    cycle(1'b1, 1'b0, '0, 1'b1);
    cycle(1'b0, 1'b0, '0, 1'b1);
    cycle(1'b0, 1'b0, '0, 1'b1);
    chk("pre_reset_straddle", 32'(inst_valid), 32'd0);
    do_reset("midreset");
    repeat (6) cycle(1'b1, 1'b0, '0, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] rpc;
      rpc = $urandom & 32'hFFFF_FFFE;
      if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 | (rpc & 32'h0000_000E);
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0, rpc,
            $urandom_range(0, 3) != 0);
    end
    chk("pop_progress", 32'(npops > 1000), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
